// File: rtl/ysyx_220066_alu_unit_pkg.sv
// ysyx_220066_alu_unit_pkg
// Shared encodings for the execute stage: operation codes carried on aluctr,
// next-PC modes carried on branch, operand-B selects carried on alu_b_src.
// The decoder and the execute unit both import this package so the two sides
// can never disagree on an encoding.
//
// aluctr layout (6 bits):
//   [5]   0 = integer ALU, 1 = multiply/divide unit
//   [4]   ALU modifier: sub instead of add, sra instead of srl
//   [3]   word form: 32-bit operation, result sign-extended to 64
//   [2:0] function select (ALU_* or MDU_* below)
package ysyx_220066_alu_unit_pkg;

    // aluctr[2:0] when aluctr[5] = 0
    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SLL  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_SRL  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    // aluctr[4:0] value that forwards operand B untouched (LUI)
    localparam logic [4:0] CTRL_LUI = 5'b11111;

    // aluctr[2:0] when aluctr[5] = 1
    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    // Full 6-bit codes commonly emitted by the decoder
    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b010000;
    localparam logic [5:0] OP_ADDW = 6'b001000;
    localparam logic [5:0] OP_LUI  = 6'b011111;
    localparam logic [5:0] OP_DIV  = 6'b100100;
    localparam logic [5:0] OP_REM  = 6'b100110;

    // branch: next-PC mode
    localparam logic [2:0] BR_SEQ  = 3'b000;
    localparam logic [2:0] BR_JAL  = 3'b001;
    localparam logic [2:0] BR_JALR = 3'b010;
    localparam logic [2:0] BR_BEQ  = 3'b100;
    localparam logic [2:0] BR_BNE  = 3'b101;
    localparam logic [2:0] BR_BLT  = 3'b110;
    localparam logic [2:0] BR_BGE  = 3'b111;

    // alu_b_src: any value with bit 1 set selects the immediate
    localparam logic [1:0] BSRC_SRC2 = 2'b00;
    localparam logic [1:0] BSRC_FOUR = 2'b01;
    localparam logic [1:0] BSRC_IMM  = 2'b10;

    localparam logic [63:0] MIN_S64 = 64'h8000_0000_0000_0000;
    localparam logic [31:0] MIN_S32 = 32'h8000_0000;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_220066_alu_unit_mdu.sv
// ysyx_220066_mdu
// Combinational RV64M multiply/divide datapath.
// Ports:
//   src1, src2  in  64  operands (always rs1/rs2, no operand muxing here)
//   aluctr      in  4   [3] word form, [2:0] MDU_* function select
//   result      out 64  product / quotient / remainder
module ysyx_220066_mdu
    import ysyx_220066_alu_unit_pkg::*;
(
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic [3:0]  aluctr,
    output logic [63:0] result
);

    logic         is_word;
    logic         a_signed;
    logic         b_signed;
    logic [127:0] mul_a;
    logic [127:0] mul_b;
    logic [127:0] prod;

    logic         dz64, ov64;
    logic [63:0]  sdiv64, udiv64;
    logic [63:0]  sq64, sr64, uq64, ur64;

    logic [31:0]  a32, b32;
    logic         dz32, ov32;
    logic [31:0]  sdiv32, udiv32;
    logic [31:0]  sq32, sr32, uq32, ur32;

    always_comb begin
        is_word  = aluctr[3];

        // One 128-bit multiplier serves every multiply flavour: operands are
        // sign- or zero-extended according to the function, and the low
        // 64 (or 32) bits are the same regardless of extension.
        a_signed = (aluctr[2:0] == MDU_MULH) || (aluctr[2:0] == MDU_MULHSU);
        b_signed = (aluctr[2:0] == MDU_MULH);
        mul_a    = {a_signed ? {64{src1[63]}} : 64'b0, src1};
        mul_b    = {b_signed ? {64{src2[63]}} : 64'b0, src2};
        prod     = mul_a * mul_b;

        // The divisor is forced to 1 in the zero and overflow cases so the
        // divider never sees them; the architectural answer is muxed in below.
        dz64   = (src2 == 64'b0);
        ov64   = (src1 == MIN_S64) && (src2 == '1);
        sdiv64 = (dz64 || ov64) ? 64'd1 : src2;
        udiv64 = dz64 ? 64'd1 : src2;
        sq64   = 64'($signed(src1) / $signed(sdiv64));
        sr64   = 64'($signed(src1) % $signed(sdiv64));
        uq64   = src1 / udiv64;
        ur64   = src1 % udiv64;

        a32    = src1[31:0];
        b32    = src2[31:0];
        dz32   = (b32 == 32'b0);
        ov32   = (a32 == MIN_S32) && (b32 == '1);
        sdiv32 = (dz32 || ov32) ? 32'd1 : b32;
        udiv32 = dz32 ? 32'd1 : b32;
        sq32   = 32'($signed(a32) / $signed(sdiv32));
        sr32   = 32'($signed(a32) % $signed(sdiv32));
        uq32   = a32 / udiv32;
        ur32   = a32 % udiv32;

        result = 64'b0;
        case (aluctr[2:0])
            MDU_MUL: begin
                result = is_word ? sext32(prod[31:0]) : prod[63:0];
            end
            MDU_MULH, MDU_MULHSU, MDU_MULHU: begin
                // No W form exists for the high-half multiplies.
                result = is_word ? 64'b0 : prod[127:64];
            end
            MDU_DIV: begin
                if (is_word) result = dz32 ? '1 : (ov32 ? sext32(a32) : sext32(sq32));
                else         result = dz64 ? '1 : (ov64 ? src1 : sq64);
            end
            MDU_DIVU: begin
                if (is_word) result = dz32 ? '1 : sext32(uq32);
                else         result = dz64 ? '1 : uq64;
            end
            MDU_REM: begin
                if (is_word) result = dz32 ? sext32(a32) : (ov32 ? 64'b0 : sext32(sr32));
                else         result = dz64 ? src1 : (ov64 ? 64'b0 : sr64);
            end
            MDU_REMU: begin
                if (is_word) result = dz32 ? sext32(a32) : sext32(ur32);
                else         result = dz64 ? src1 : ur64;
            end
            default: result = 64'b0;
        endcase
    end

endmodule

// File: rtl/ysyx_220066_alu_unit.sv
// ysyx_220066_alu_unit
// Execute stage: integer ALU, multiply/divide unit and next-PC calculation,
// with the result, next PC and valid registered once (1-cycle latency,
// one operation per cycle, never stalls).
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   valid_in              operands valid this cycle
//   src1, src2, imm       rs1, rs2, immediate
//   in_pc                 PC of the instruction
//   alu_a_src             1 = A is in_pc, 0 = A is src1
//   alu_b_src             1x = imm, 01 = 4, 00 = src2
//   aluctr                operation code (see package)
//   branch                next-PC mode (see package)
//   result, nxtpc         registered result and next PC
//   valid_out             valid_in delayed one cycle
module ysyx_220066_alu_unit
    import ysyx_220066_alu_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic [63:0] src1,
    input  logic [63:0] src2,
    input  logic [63:0] imm,
    input  logic [63:0] in_pc,
    input  logic        alu_a_src,
    input  logic [1:0]  alu_b_src,
    input  logic [5:0]  aluctr,
    input  logic [2:0]  branch,
    output logic [63:0] result,
    output logic [63:0] nxtpc,
    output logic        valid_out
);

    logic [63:0] op_a, op_b;
    logic        is_word;
    logic [63:0] sum;
    logic [5:0]  shamt;
    logic [63:0] sll64, srl64, sra64;
    logic [31:0] sllw, srlw, sraw;
    logic [63:0] alu_raw, alu_res;
    logic        zero;
    logic [63:0] mdu_res;

    logic [63:0] pc_plus4, pc_imm, jalr_tgt;

    logic [63:0] result_d, result_q;
    logic [63:0] nxtpc_d, nxtpc_q;
    logic        valid_d, valid_q;

    ysyx_220066_mdu u_mdu (
        .src1   (src1),
        .src2   (src2),
        .aluctr (aluctr[3:0]),
        .result (mdu_res)
    );

    // Integer ALU
    always_comb begin
        op_a = alu_a_src ? in_pc : src1;
        if (alu_b_src[1])               op_b = imm;
        else if (alu_b_src == BSRC_FOUR) op_b = 64'h4;
        else                            op_b = src2;

        is_word = aluctr[3];
        sum     = aluctr[4] ? (op_a - op_b) : (op_a + op_b);
        shamt   = op_b[5:0];
        sll64   = op_a << shamt;
        srl64   = op_a >> shamt;
        sra64   = 64'($signed(op_a) >>> shamt);
        sllw    = op_a[31:0] << op_b[4:0];
        srlw    = op_a[31:0] >> op_b[4:0];
        sraw    = 32'($signed(op_a[31:0]) >>> op_b[4:0]);

        alu_raw = 64'b0;
        case (aluctr[2:0])
            ALU_ADD:  alu_raw = sum;
            ALU_SLL:  alu_raw = is_word ? {32'b0, sllw} : sll64;
            ALU_SLT:  alu_raw = ($signed(op_a) < $signed(op_b)) ? 64'd1 : 64'd0;
            ALU_SLTU: alu_raw = (op_a < op_b) ? 64'd1 : 64'd0;
            ALU_XOR:  alu_raw = op_a ^ op_b;
            ALU_SRL: begin
                if (is_word) alu_raw = {32'b0, aluctr[4] ? sraw : srlw};
                else         alu_raw = aluctr[4] ? sra64 : srl64;
            end
            ALU_OR:   alu_raw = op_a | op_b;
            ALU_AND:  alu_raw = op_a & op_b;
            default:  alu_raw = 64'b0;
        endcase

        alu_res = is_word ? sext32(alu_raw[31:0]) : alu_raw;
        // LUI's code overlaps a word-form AND; it must win outright.
        if (aluctr[4:0] == CTRL_LUI) alu_res = op_b;

        zero     = (alu_res == 64'b0);
        result_d = aluctr[5] ? mdu_res : alu_res;
    end

    // Next PC. Conditional branches rely on the ALU having been asked for a
    // sub (beq/bne, via zero) or slt/sltu (blt/bge, via result bit 0).
    always_comb begin
        pc_plus4 = in_pc + 64'h4;
        pc_imm   = in_pc + imm;
        jalr_tgt = (src1 + imm) & ~64'h1;

        nxtpc_d = pc_plus4;
        case (branch)
            BR_JAL:  nxtpc_d = pc_imm;
            BR_JALR: nxtpc_d = jalr_tgt;
            BR_BEQ:  nxtpc_d = zero ? pc_imm : pc_plus4;
            BR_BNE:  nxtpc_d = zero ? pc_plus4 : pc_imm;
            BR_BLT:  nxtpc_d = result_d[0] ? pc_imm : pc_plus4;
            BR_BGE:  nxtpc_d = result_d[0] ? pc_plus4 : pc_imm;
            default: nxtpc_d = pc_plus4;
        endcase

        valid_d = valid_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 64'b0;
            nxtpc_q  <= 64'b0;
            valid_q  <= 1'b0;
        end else begin
            result_q <= result_d;
            nxtpc_q  <= nxtpc_d;
            valid_q  <= valid_d;
        end
    end

    assign result    = result_q;
    assign nxtpc     = nxtpc_q;
    assign valid_out = valid_q;

endmodule

// File: tb/tb_ysyx_220066_alu_unit.sv
module tb_ysyx_220066_alu_unit;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic [63:0] src1, src2, imm, in_pc;
    logic        alu_a_src;
    logic [1:0]  alu_b_src;
    logic [5:0]  aluctr;
    logic [2:0]  branch;
    logic [63:0] result, nxtpc;
    logic        valid_out;

    int errors = 0;
    int checks = 0;

    // Each entry: {valid, result, nxtpc}
    logic [128:0] exp_q[$];

    ysyx_220066_alu_unit dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .src1      (src1),
        .src2      (src2),
        .imm       (imm),
        .in_pc     (in_pc),
        .alu_a_src (alu_a_src),
        .alu_b_src (alu_b_src),
        .aluctr    (aluctr),
        .branch    (branch),
        .result    (result),
        .nxtpc     (nxtpc),
        .valid_out (valid_out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic defaults();
        valid_in  = 1'b1;
        src1      = 64'h0;
        src2      = 64'h0;
        imm       = 64'h0;
        in_pc     = 64'h1000;
        alu_a_src = 1'b0;
        alu_b_src = 2'b00;
        aluctr    = 6'b000000;
        branch    = 3'b000;
    endtask

    // Push the expectation for the inputs currently driven, let one edge
    // pass, then pop and compare against the registered outputs.
    task automatic step(input string tag, input logic v, input logic [63:0] r, input logic [63:0] pc);
        logic [128:0] e;
        exp_q.push_back({v, r, pc});
        @(posedge clk);
        #1;
        checks++;
        assert (exp_q.size() != 0) else begin
            errors++;
            $error("FAIL %s_queue: observed=empty expected=entry", tag);
        end
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check64({tag, "_valid"},  {63'b0, valid_out}, {63'b0, e[128]});
            check64({tag, "_result"}, result, e[127:64]);
            check64({tag, "_nxtpc"},  nxtpc,  e[63:0]);
        end
    endtask

    initial begin
        logic [63:0] ra, rb, rpc, rexp;
        int unsigned sel;

        // Reset with live-looking inputs
        defaults();
        rst  = 1'b1;
        src1 = 64'd5;
        src2 = 64'd7;
        step("reset", 1'b0, 64'h0, 64'h0);
        rst = 1'b0;

        // add
        defaults(); src1 = 64'd5; src2 = 64'd7;
        step("add", 1'b1, 64'd12, 64'h1004);

        // addw wraps into the sign bit of the 32-bit result
        defaults(); src1 = 64'h7FFF_FFFF; imm = 64'd1; alu_b_src = 2'b10; aluctr = 6'b001000;
        step("addw", 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h1004);

        // beq taken / not taken
        defaults(); src1 = 64'd3; src2 = 64'd3; aluctr = 6'b010000; branch = 3'b100;
        in_pc = 64'h8000_0000; imm = 64'h10;
        step("beq_t", 1'b1, 64'h0, 64'h8000_0010);
        src2 = 64'd4;
        step("beq_nt", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0004);
        branch = 3'b101;
        step("bne_t", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0010);

        // div / rem corners
        defaults(); src1 = 64'd100; src2 = 64'd0; aluctr = 6'b100100;
        step("div_zero", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1004);
        aluctr = 6'b100110;
        step("rem_zero", 1'b1, 64'd100, 64'h1004);
        src1 = 64'h8000_0000_0000_0000; src2 = 64'hFFFF_FFFF_FFFF_FFFF; aluctr = 6'b100100;
        step("div_ovf", 1'b1, 64'h8000_0000_0000_0000, 64'h1004);
        aluctr = 6'b100110;
        step("rem_ovf", 1'b1, 64'h0, 64'h1004);
        src1 = 64'd100; src2 = 64'hFFFF_FFFF_FFFF_FFF9; aluctr = 6'b100100;  // 100 / -7
        step("div_neg", 1'b1, 64'hFFFF_FFFF_FFFF_FFF2, 64'h1004);

        // multiplies
        defaults(); src1 = '1; src2 = '1; aluctr = 6'b100011;
        step("mulhu", 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'h1004);
        src1 = 64'd3; src2 = 64'hFFFF_FFFF_FFFF_FFFE; aluctr = 6'b100000;
        step("mul", 1'b1, 64'hFFFF_FFFF_FFFF_FFFA, 64'h1004);
        src1 = 64'h8000_0000_0000_0000; src2 = 64'd2; aluctr = 6'b100001;
        step("mulh", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1004);
        aluctr = 6'b100011;
        step("mulhu2", 1'b1, 64'h1, 64'h1004);
        aluctr = 6'b101001;
        step("mulhw_undef", 1'b1, 64'h0, 64'h1004);

        // W-form divides
        defaults(); src1 = 64'hFFFF_FFFF_8000_0000; src2 = 64'h0000_0000_FFFF_FFFF; aluctr = 6'b101100;
        step("divw_ovf", 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h1004);
        src1 = 64'd9; src2 = 64'hFFFF_FFFF_0000_0000; aluctr = 6'b101101;
        step("divuw_zero", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1004);
        src1 = 64'hFFFF_FFFF_FFFF_FFF9; src2 = 64'd2; aluctr = 6'b101110;
        step("remw", 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1004);

        // jalr clears bit 0; link value is pc+4 through A=pc, B=4
        defaults(); src1 = 64'h1001; imm = 64'h0; branch = 3'b010;
        in_pc = 64'h2000; alu_a_src = 1'b1; alu_b_src = 2'b01;
        step("jalr", 1'b1, 64'h2004, 64'h1000);
        branch = 3'b001; imm = 64'h100;
        step("jal", 1'b1, 64'h2004, 64'h2100);
        branch = 3'b011;
        step("br011", 1'b1, 64'h2004, 64'h2004);

        // blt / bge / bltu
        defaults(); src1 = '1; src2 = 64'd1; imm = 64'h40; aluctr = 6'b000010; branch = 3'b110;
        step("blt_t", 1'b1, 64'd1, 64'h1040);
        branch = 3'b111;
        step("bge_nt", 1'b1, 64'd1, 64'h1004);
        aluctr = 6'b000011; branch = 3'b110;
        step("bltu_nt", 1'b1, 64'd0, 64'h1004);

        // shifts and lui
        defaults(); src1 = 64'h8000_0000_0000_0000; src2 = 64'd4; aluctr = 6'b010101;
        step("sra", 1'b1, 64'hF800_0000_0000_0000, 64'h1004);
        src1 = 64'd1; src2 = 64'd31; aluctr = 6'b001001;
        step("sllw", 1'b1, 64'hFFFF_FFFF_8000_0000, 64'h1004);
        src1 = 64'hFFFF_FFFF_8000_0000; src2 = 64'd4; aluctr = 6'b001101;
        step("srlw", 1'b1, 64'h0000_0000_0800_0000, 64'h1004);
        src1 = 64'd1; src2 = 64'd63; aluctr = 6'b000001;
        step("sll63", 1'b1, 64'h8000_0000_0000_0000, 64'h1004);
        defaults(); imm = 64'h1234_5000; alu_b_src = 2'b10; aluctr = 6'b011111;
        step("lui", 1'b1, 64'h1234_5000, 64'h1004);

        // valid_in low still registers the datapath
        defaults(); valid_in = 1'b0; src1 = 64'd1; src2 = 64'd2;
        step("invalid", 1'b0, 64'd3, 64'h1004);

        // Random add / sub / xor / and
        for (int i = 0; i < 8; i++) begin
            defaults();
            ra  = {$urandom, $urandom};
            rb  = {$urandom, $urandom};
            rpc = {$urandom, $urandom};
            sel = $urandom_range(0, 3);
            src1 = ra; src2 = rb; in_pc = rpc;
            case (sel)
                0: begin aluctr = 6'b000000; rexp = ra + rb; end
                1: begin aluctr = 6'b010000; rexp = ra - rb; end
                2: begin aluctr = 6'b000100; rexp = ra ^ rb; end
                default: begin aluctr = 6'b000111; rexp = ra & rb; end
            endcase
            step("rand", 1'b1, rexp, rpc + 64'h4);
        end

        // Reset mid-stream, then first edge after release registers normally
        defaults(); rst = 1'b1; src1 = 64'd5; src2 = 64'd7; imm = 64'h30; branch = 3'b001;
        step("rst_mid", 1'b0, 64'h0, 64'h0);
        rst = 1'b0;
        step("after_rst", 1'b1, 64'd12, 64'h1030);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_220066_alu_unit.md
YSYX_220066_ALU_UNIT -- requirements
Module: ysyx_220066_alu_unit

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have port: valid_in  input  1  operands valid this cycle.
REQ-004 SHALL have ports: src1, src2, imm, in_pc  input  64 each  rs1 value, rs2 value, immediate, instruction PC.
REQ-005 SHALL have port: alu_a_src  input  1  operand A select; 1 = in_pc, 0 = src1.
REQ-006 SHALL have port: alu_b_src  input  2  operand B select; 1x = imm, 01 = 64'h4, 00 = src2.
REQ-007 SHALL have port: aluctr  input  6  operation code (REQ-012..015).
REQ-008 SHALL have port: branch  input  3  next-PC mode (REQ-017).
REQ-009 SHALL have ports: result, nxtpc  output  64 each  registered ALU/MDU result and next PC.
REQ-010 SHALL have port: valid_out  output  1  valid_in delayed one cycle.

Function
REQ-011 SHALL compute combinationally, then register result, nxtpc and valid_out on every clk edge; latency exactly 1 cycle, throughput 1/cycle, no stall.
REQ-012 SHALL select the integer ALU when aluctr[5]=0 and the multiply/divide unit when aluctr[5]=1; A/B selection (REQ-005/006) applies to the ALU only; the MDU always uses src1/src2.
REQ-013 ALU SHALL decode aluctr[2:0]: 000 add (sub if aluctr[4]), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl (sra if aluctr[4]), 110 or, 111 and; aluctr[4:0]=11111 SHALL pass B unchanged (LUI).
REQ-014 aluctr[3]=1 (word op) SHALL operate on low 32 bits, shift amount B[4:0], sign-extend the 32-bit result to 64; otherwise shift amount B[5:0].
REQ-015 MDU SHALL decode aluctr[2:0]: 000 mul (low 64), 001 mulh (s×s), 010 mulhsu (s×u), 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu; aluctr[3]=1 gives the RV64 W form (32-bit operands, sign-extended 32-bit result; mulh* codes with W are undefined, output 0).
REQ-016 Division by zero SHALL give quotient all ones and remainder equal to dividend; signed overflow (most-negative ÷ -1) SHALL give quotient = dividend and remainder 0; the same rules apply at 32-bit width for W forms.
REQ-017 Next PC SHALL be: 000 in_pc+4; 001 in_pc+imm (jal); 010 (src1+imm) with bit0 cleared (jalr); 100 beq: in_pc+imm if zero else +4; 101 bne: if !zero; 110 blt/bltu: if result[0]; 111 bge/bgeu: if !result[0]; 011 SHALL behave as 000.
REQ-018 zero SHALL be 1 when the ALU result is all zeros; result[0] in REQ-017 is the final muxed result; branches use sub (beq/bne) or slt/sltu (blt*/bge*).
REQ-019 All adds SHALL wrap modulo 2^64; no overflow flag.

Reset
REQ-020 When rst is high at a clk edge, result, nxtpc and valid_out SHALL become 0, overriding valid_in and operands.
REQ-021 The first edge after rst deasserts SHALL register normally; no residual state exists beyond the output registers.

Structure
REQ-022 The aluctr codes, branch codes and alu_b_src codes SHALL be defined as named constants in a shared package used by the decoder and this block.
REQ-023 The multiply/divide datapath SHALL be one sub-module, ysyx_220066_mdu (combinational, inputs src1/src2/aluctr[3:0], output 64-bit result); ALU, next-PC logic and output registers stay in the top.

Verification
REQ-024 add: src1=5, src2=7, aluctr=000000, alu_a_src=0, alu_b_src=00 -> result 12 one cycle later, valid_out=1.
REQ-025 addw overflow: src1=0x7FFFFFFF, imm=1, alu_b_src=10, aluctr=001000 -> result 0xFFFFFFFF80000000.
REQ-026 beq taken: src1=src2=3, aluctr=010000, branch=100, in_pc=0x80000000, imm=0x10 -> nxtpc 0x80000010; src2=4 -> 0x80000004.
REQ-027 div corner: aluctr=100100, src2=0 -> result all ones; src1=0x8000000000000000, src2=-1 -> result 0x8000000000000000; rem (100110) same inputs -> 0.
REQ-028 mulhu: src1=src2=all ones, aluctr=100011 -> result 0xFFFFFFFFFFFFFFFE; jalr src1=0x1001, imm=0, branch=010 -> nxtpc 0x1000.
REQ-029 Reset mid-stream: rst=1 with valid_in=1 and nonzero operands -> next edge result=nxtpc=0, valid_out=0.
